// File: rtl/cpc_bus_master.sv
// Host-side Z80 bus-cycle initiator for the CPC expansion connector.
// Runs one memory or I/O read/write per command with T-state strobe timing and READY wait states.
module cpc_bus_master #(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_ramdis,
    output logic        rsp_timeout,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        MREQ_B,
    output logic        IOREQ_B,
    output logic        RD_B,
    output logic        WR_B,
    output logic        M1_B,
    output logic        RFSH_B,
    input  logic        READY,
    input  logic        RAMDIS
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_TWA  = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T3   = 3'd5;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        tmo_q, tmo_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        mreq_q, mreq_d;
    logic        ioreq_q, ioreq_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_ramdis_q, rsp_ramdis_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic sample_ready;
    logic is_mem, is_write, busy, late_phase, io_phase;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wcnt_d        = wcnt_q;
        tmo_d         = tmo_q;
        a_d           = a_q;
        dout_d        = dout_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_ramdis_d  = rsp_ramdis_q;
        rsp_timeout_d = rsp_timeout_q;
        sample_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_T1;
                    op_d    = cmd_op;
                    a_d     = cmd_addr;
                    dout_d  = cmd_wdata;
                    wcnt_d  = 8'd0;
                    tmo_d   = 1'b0;
                end
            end
            S_T1:  state_d = S_T2;
            // I/O cycles always insert TWA before READY is looked at
            S_T2: begin
                if (op_q[1]) state_d = S_TWA;
                else         sample_ready = 1'b1;
            end
            S_TWA, S_TW: sample_ready = 1'b1;
            S_T3: begin
                state_d       = S_IDLE;
                rsp_valid_d   = 1'b1;
                rsp_timeout_d = tmo_q;
                if (op_q[0])    rsp_rdata_d = 8'h00;
                else if (tmo_q) rsp_rdata_d = 8'hFF;
                else            rsp_rdata_d = D_in;
                rsp_ramdis_d  = (op_q == 2'b00) ? RAMDIS : 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (sample_ready) begin
            if (READY) begin
                state_d = S_T3;
            end else if (wcnt_q >= MAX_W) begin
                state_d = S_T3;
                tmo_d   = 1'b1;
            end else begin
                state_d = S_TW;
                wcnt_d  = wcnt_q + 8'd1;
            end
        end

        // Strobes are registered, so they are decoded from where the FSM is going
        is_mem     = ~op_d[1];
        is_write   = op_d[0];
        busy       = (state_d != S_IDLE);
        late_phase = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
        io_phase   = late_phase || (state_d == S_TWA);

        mreq_d  = ~(is_mem & busy);
        ioreq_d = ~(~is_mem & io_phase);
        rd_d    = ~(~is_write & (is_mem ? busy : io_phase));
        wr_d    = ~(is_write & (is_mem ? late_phase : io_phase));
        doe_d   = is_write & busy;
        ready_d = ~busy;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            op_q          <= 2'b00;
            wcnt_q        <= 8'd0;
            tmo_q         <= 1'b0;
            a_q           <= 16'h0000;
            dout_q        <= 8'h00;
            doe_q         <= 1'b0;
            mreq_q        <= 1'b1;
            ioreq_q       <= 1'b1;
            rd_q          <= 1'b1;
            wr_q          <= 1'b1;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_ramdis_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wcnt_q        <= wcnt_d;
            tmo_q         <= tmo_d;
            a_q           <= a_d;
            dout_q        <= dout_d;
            doe_q         <= doe_d;
            mreq_q        <= mreq_d;
            ioreq_q       <= ioreq_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            ready_q       <= ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_ramdis_q  <= rsp_ramdis_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ramdis  = rsp_ramdis_q;
    assign rsp_timeout = rsp_timeout_q;
    assign A           = a_q;
    assign D_out       = dout_q;
    assign D_oe        = doe_q;
    assign MREQ_B      = mreq_q;
    assign IOREQ_B     = ioreq_q;
    assign RD_B        = rd_q;
    assign WR_B        = wr_q;
    assign M1_B        = 1'b1;
    assign RFSH_B      = 1'b1;

endmodule

// File: tb/tb_cpc_bus_master.sv
// Directed bench for cpc_bus_master: strobe widths, latency, wait states, timeout,
// mid-cycle reset and back-to-back commands, all against hand-computed values.
module tb_cpc_bus_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_ramdis;
    logic        rsp_timeout;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in = 8'h00;
    logic        MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
    logic        READY = 1'b1;
    logic        RAMDIS = 1'b0;

    int tests_run = 0;
    int fails = 0;

    // Per-transaction observations filled by run_cmd
    int          lat, n_mreq, n_ioreq, n_rd, n_wr;
    logic        got;
    logic [15:0] t1_a;
    logic        t1_doe, t1_ioreq, dout_bad;

    cpc_bus_master #(.MAX_WAIT(15)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ramdis(rsp_ramdis),
        .rsp_timeout(rsp_timeout),
        .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
        .M1_B(M1_B), .RFSH_B(RFSH_B), .READY(READY), .RAMDIS(RAMDIS)
    );

    always #5 CLK = ~CLK;

    // n counts negedges after the accept edge; READY is held low while n < ready_until
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr,
                           input logic [7:0] wd, input int ready_until);
        int n;
        @(negedge CLK);
        tests_run++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_idle: got %b exp 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; READY = 1'b1;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        n = 0; got = 1'b0; lat = 0;
        n_mreq = 0; n_ioreq = 0; n_rd = 0; n_wr = 0; dout_bad = 1'b0;
        while (!got && n < 200) begin
            @(negedge CLK);
            n++;
            READY = (n < ready_until) ? 1'b0 : 1'b1;
            if (n == 1) begin t1_a = A; t1_doe = D_oe; t1_ioreq = IOREQ_B; end
            if (MREQ_B == 1'b0)  n_mreq++;
            if (IOREQ_B == 1'b0) n_ioreq++;
            if (RD_B == 1'b0)    n_rd++;
            if (WR_B == 1'b0) begin
                n_wr++;
                if (D_out !== wd || D_oe !== 1'b1) dout_bad = 1'b1;
            end
            if (rsp_valid === 1'b1) begin got = 1'b1; lat = n; end
        end
        READY = 1'b1;
        tests_run++; if (got !== 1'b1) begin fails++; $display("FAIL rsp_arrival: no rsp_valid within 200 cycles for addr %h", addr); end
        $display("[TB] op=%b addr=%h wdata=%h lat=%0d mreq=%0d ioreq=%0d rd=%0d wr=%0d rdata=%h ramdis=%b tmo=%b",
                 op, addr, wd, lat, n_mreq, n_ioreq, n_rd, n_wr, rsp_rdata, rsp_ramdis, rsp_timeout);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests_run++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
        tests_run++; if ({MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B} !== 6'b111111) begin fails++; $display("FAIL reset_strobes: got %b exp 111111", {MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B}); end
        tests_run++; if ({D_oe, A, D_out} !== 25'd0) begin fails++; $display("FAIL reset_bus: got oe=%b A=%h D=%h exp 0/0000/00", D_oe, A, D_out); end
        tests_run++; if ({rsp_valid, rsp_rdata, rsp_ramdis, rsp_timeout} !== 11'd0) begin fails++; $display("FAIL reset_rsp: got v=%b d=%h r=%b t=%b exp all 0", rsp_valid, rsp_rdata, rsp_ramdis, rsp_timeout); end
        RESET = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_mem_read;
        D_in = 8'h5A; RAMDIS = 1'b1;
        run_cmd(2'b00, 16'h4000, 8'h00, 0);
        tests_run++; if (n_mreq !== 3 || n_rd !== 3) begin fails++; $display("FAIL memrd_strobes: got mreq=%0d rd=%0d exp 3/3", n_mreq, n_rd); end
        tests_run++; if (n_wr !== 0 || n_ioreq !== 0) begin fails++; $display("FAIL memrd_idle_strobes: got wr=%0d ioreq=%0d exp 0/0", n_wr, n_ioreq); end
        tests_run++; if (lat !== 4) begin fails++; $display("FAIL memrd_latency: got %0d exp 4", lat); end
        tests_run++; if (rsp_rdata !== 8'h5A || rsp_ramdis !== 1'b1 || rsp_timeout !== 1'b0) begin fails++; $display("FAIL memrd_rsp: got d=%h r=%b t=%b exp 5a/1/0", rsp_rdata, rsp_ramdis, rsp_timeout); end
        @(negedge CLK);
        tests_run++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h5A) begin fails++; $display("FAIL memrd_pulse_hold: got v=%b d=%h exp 0/5a", rsp_valid, rsp_rdata); end
        RAMDIS = 1'b0;
    endtask

    task automatic test_io_write;
        run_cmd(2'b11, 16'h7FFF, 8'hC4, 0);
        tests_run++; if (t1_a !== 16'h7FFF || t1_doe !== 1'b1 || t1_ioreq !== 1'b1) begin fails++; $display("FAIL iowr_t1: got A=%h oe=%b ioreq=%b exp 7fff/1/1", t1_a, t1_doe, t1_ioreq); end
        tests_run++; if (n_ioreq !== 3 || n_wr !== 3) begin fails++; $display("FAIL iowr_strobes: got ioreq=%0d wr=%0d exp 3/3", n_ioreq, n_wr); end
        tests_run++; if (n_mreq !== 0 || n_rd !== 0 || dout_bad !== 1'b0) begin fails++; $display("FAIL iowr_other: got mreq=%0d rd=%0d dout_bad=%b exp 0/0/0", n_mreq, n_rd, dout_bad); end
        tests_run++; if (lat !== 5) begin fails++; $display("FAIL iowr_latency: got %0d exp 5", lat); end
        tests_run++; if (rsp_rdata !== 8'h00 || rsp_timeout !== 1'b0 || rsp_ramdis !== 1'b0) begin fails++; $display("FAIL iowr_rsp: got d=%h t=%b r=%b exp 00/0/0", rsp_rdata, rsp_timeout, rsp_ramdis); end
        tests_run++; if (A !== 16'h7FFF || D_oe !== 1'b0) begin fails++; $display("FAIL iowr_after: got A=%h oe=%b exp 7fff/0", A, D_oe); end
    endtask

    task automatic test_mem_write_wait;
        run_cmd(2'b01, 16'h8123, 8'h9E, 4);
        tests_run++; if (n_wr !== 4 || n_mreq !== 5) begin fails++; $display("FAIL memwr_wait_strobes: got wr=%0d mreq=%0d exp 4/5", n_wr, n_mreq); end
        tests_run++; if (lat !== 6 || rsp_timeout !== 1'b0) begin fails++; $display("FAIL memwr_wait_rsp: got lat=%0d t=%b exp 6/0", lat, rsp_timeout); end
        tests_run++; if (dout_bad !== 1'b0 || n_rd !== 0) begin fails++; $display("FAIL memwr_wait_data: got dout_bad=%b rd=%0d exp 0/0", dout_bad, n_rd); end
    endtask

    task automatic test_timeout;
        D_in = 8'h12; RAMDIS = 1'b0;
        run_cmd(2'b00, 16'h0100, 8'h00, 1000);
        tests_run++; if (lat !== 19 || n_mreq !== 18) begin fails++; $display("FAIL tmo_length: got lat=%0d mreq=%0d exp 19/18", lat, n_mreq); end
        tests_run++; if (rsp_rdata !== 8'hFF || rsp_timeout !== 1'b1) begin fails++; $display("FAIL tmo_rsp: got d=%h t=%b exp ff/1", rsp_rdata, rsp_timeout); end
        D_in = 8'h3C; RAMDIS = 1'b1;
        run_cmd(2'b10, 16'h00FE, 8'h00, 0);
        tests_run++; if (lat !== 5 || n_ioreq !== 3 || n_rd !== 3) begin fails++; $display("FAIL tmo_next_cycle: got lat=%0d ioreq=%0d rd=%0d exp 5/3/3", lat, n_ioreq, n_rd); end
        tests_run++; if (rsp_rdata !== 8'h3C || rsp_timeout !== 1'b0 || rsp_ramdis !== 1'b0) begin fails++; $display("FAIL tmo_next_rsp: got d=%h t=%b r=%b exp 3c/0/0", rsp_rdata, rsp_timeout, rsp_ramdis); end
        RAMDIS = 1'b0;
    endtask

    task automatic test_reset_mid_cycle;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 16'hBC00; READY = 1'b0;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge CLK);
        tests_run++; if (IOREQ_B !== 1'b0 || RD_B !== 1'b0) begin fails++; $display("FAIL rstmid_in_tw: got ioreq=%b rd=%b exp 0/0", IOREQ_B, RD_B); end
        #1 RESET = 1'b1;
        #1;
        tests_run++; if ({MREQ_B, IOREQ_B, RD_B, WR_B} !== 4'b1111 || D_oe !== 1'b0) begin fails++; $display("FAIL rstmid_async: got strobes=%b oe=%b exp 1111/0", {MREQ_B, IOREQ_B, RD_B, WR_B}, D_oe); end
        tests_run++; if (A !== 16'h0000 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_state: got A=%h ready=%b exp 0000/1", A, cmd_ready); end
        @(negedge CLK);
        tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_rsp: got %b exp 0", rsp_valid); end
        RESET = 1'b0; READY = 1'b1;
        @(negedge CLK);
        tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_rsp_after: got %b exp 0", rsp_valid); end
        $display("[TB] reset during TW of io read 0xbc00");
        D_in = 8'h81;
        run_cmd(2'b10, 16'hBC00, 8'h00, 0);
        tests_run++; if (lat !== 5 || rsp_rdata !== 8'h81 || rsp_timeout !== 1'b0) begin fails++; $display("FAIL rstmid_resume: got lat=%0d d=%h t=%b exp 5/81/0", lat, rsp_rdata, rsp_timeout); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h1000; D_in = 8'h11; READY = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        tests_run++; if (n !== 4 || rsp_rdata !== 8'h11) begin fails++; $display("FAIL b2b_first: got lat=%0d d=%h exp 4/11", n, rsp_rdata); end
        tests_run++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_in_rsp: got %b exp 1", cmd_ready); end
        $display("[TB] b2b first mem read 1000 lat=%0d rdata=%h", n, rsp_rdata);
        cmd_addr = 16'h2000; D_in = 8'h22;
        @(negedge CLK);
        cmd_valid = 1'b0;
        tests_run++; if (MREQ_B !== 1'b0 || A !== 16'h2000 || rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_second_t1: got mreq=%b A=%h v=%b exp 0/2000/0", MREQ_B, A, rsp_valid); end
        n = 1;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        tests_run++; if (n !== 4 || rsp_rdata !== 8'h22) begin fails++; $display("FAIL b2b_second: got lat=%0d d=%h exp 4/22", n, rsp_rdata); end
        $display("[TB] b2b second mem read 2000 lat=%0d rdata=%h", n, rsp_rdata);
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_mem_write_wait();
        test_timeout();
        test_reset_mid_cycle();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
